// File: rtl/aes_dec_ctrl.sv
// rtl/aes_dec_ctrl.sv - AES decryption round-sequencing controller
//
// Sequences one 128-bit ciphertext block through an external combinational
// inverse-round datapath: AddRoundKey(NR), NR-1 full inverse rounds, then the
// final inverse round. All outputs are registered.
//
// Optional feature: define AES_DEC_CTRL_BLKCNT_EN to add the 16-bit blk_cnt
// output counting out_valid & out_ready handshakes (wraps at 0xFFFF).
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    ciphertext handshake, in_data = ciphertext block
//   key_valid            expanded round keys usable (sampled in IDLE/WAIT_KEY)
//   dp_state             working state to the datapath
//   dp_sel               0 AddRoundKey, 1 full inv round, 2 final inv round, 3 idle
//   dp_key_idx           round-key index for the datapath
//   dp_result            combinational datapath result
//   out_valid/out_ready  plaintext handshake, out_data = plaintext
//   busy                 high outside IDLE
//   done_led             sticky completion flag, cleared on next accept
//   blk_cnt              (optional) completed-block counter
module aes_dec_ctrl #(
    parameter int NR  = 10,
    parameter int KIW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    input  logic           key_valid,
    output logic [127:0]   dp_state,
    output logic [1:0]     dp_sel,
    output logic [KIW-1:0] dp_key_idx,
    input  logic [127:0]   dp_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data,
`ifdef AES_DEC_CTRL_BLKCNT_EN
    output logic [15:0]    blk_cnt,
`endif
    output logic           busy,
    output logic           done_led
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_KEY,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [KIW-1:0] IDX_NR   = KIW'(NR);
    localparam logic [KIW-1:0] IDX_LAST = KIW'(NR - 1);
    localparam logic [KIW-1:0] IDX_ONE  = KIW'(1);

    state_t         state_q, state_d;
    logic [127:0]   dp_state_q, dp_state_d;
    logic [1:0]     dp_sel_q, dp_sel_d;
    logic [KIW-1:0] dp_key_idx_q, dp_key_idx_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;
    logic           done_led_q, done_led_d;
`ifdef AES_DEC_CTRL_BLKCNT_EN
    logic [15:0]    blk_cnt_q, blk_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        dp_state_d   = dp_state_q;
        done_led_d   = done_led_q;
        dp_sel_d     = 2'd3;
        dp_key_idx_d = '0;

        // Next-state and working-state update for the current state.
        case (state_q)
            S_IDLE: begin
                // in_ready is high in IDLE, so in_valid alone is an accept.
                if (in_valid) begin
                    dp_state_d = in_data;
                    done_led_d = 1'b0;
                    state_d    = key_valid ? S_INIT : S_WAIT_KEY;
                end
            end
            S_WAIT_KEY: begin
                if (key_valid) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                dp_state_d = dp_result;
                state_d    = S_ROUND;
            end
            S_ROUND: begin
                dp_state_d = dp_result;
                if (dp_key_idx_q == IDX_ONE) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                dp_state_d = dp_result;
                done_led_d = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered outputs are derived from the state being entered so they
        // line up with that state's cycle.
        case (state_d)
            S_INIT: begin
                dp_sel_d     = 2'd0;
                dp_key_idx_d = IDX_NR;
            end
            S_ROUND: begin
                dp_sel_d     = 2'd1;
                dp_key_idx_d = (state_q == S_INIT) ? IDX_LAST : (dp_key_idx_q - IDX_ONE);
            end
            S_FINAL: begin
                dp_sel_d     = 2'd2;
                dp_key_idx_d = '0;
            end
            default: begin
                dp_sel_d     = 2'd3;
                dp_key_idx_d = '0;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        out_valid_d = (state_d == S_DONE);

`ifdef AES_DEC_CTRL_BLKCNT_EN
        blk_cnt_d = blk_cnt_q + ((out_valid_q && out_ready) ? 16'd1 : 16'd0);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dp_state_q   <= '0;
            dp_sel_q     <= 2'd3;
            dp_key_idx_q <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_led_q   <= 1'b0;
`ifdef AES_DEC_CTRL_BLKCNT_EN
            blk_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            dp_state_q   <= dp_state_d;
            dp_sel_q     <= dp_sel_d;
            dp_key_idx_q <= dp_key_idx_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_led_q   <= done_led_d;
`ifdef AES_DEC_CTRL_BLKCNT_EN
            blk_cnt_q    <= blk_cnt_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign dp_state   = dp_state_q;
    assign dp_sel     = dp_sel_q;
    assign dp_key_idx = dp_key_idx_q;
    assign out_valid  = out_valid_q;
    assign out_data   = dp_state_q;
    assign busy       = busy_q;
    assign done_led   = done_led_q;
`ifdef AES_DEC_CTRL_BLKCNT_EN
    assign blk_cnt    = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// tb/tb_aes_dec_ctrl.sv - self-checking bench for aes_dec_ctrl
module tb_aes_dec_ctrl;

    localparam int NR  = 10;
    localparam int KIW = 4;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [127:0]   in_data = '0;
    logic           key_valid = 1'b1;
    logic [127:0]   dp_state;
    logic [1:0]     dp_sel;
    logic [KIW-1:0] dp_key_idx;
    logic [127:0]   dp_result;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [127:0]   out_data;
    logic           busy;
    logic           done_led;
`ifdef AES_DEC_CTRL_BLKCNT_EN
    logic [15:0]    blk_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    aes_dec_ctrl #(.NR(NR), .KIW(KIW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .key_valid  (key_valid),
        .dp_state   (dp_state),
        .dp_sel     (dp_sel),
        .dp_key_idx (dp_key_idx),
        .dp_result  (dp_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef AES_DEC_CTRL_BLKCNT_EN
        .blk_cnt    (blk_cnt),
`endif
        .busy       (busy),
        .done_led   (done_led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- AES reference arithmetic ----------------
    logic [7:0]   sbox [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] rk [11];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic init_tables();
        logic [7:0] inv, s, c;
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rcon;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox[x] = s;
            inv_sbox[s] = 8'(x);
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t ^= {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Bytes are column-major: byte n sits at bits [127-8n -: 8], row n%4, column n/4.
    function automatic logic [127:0] inv_shr(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = inv_sbox[s[127-8*n -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-8*(4*c)   -: 8];
            a1 = s[127-8*(4*c+1) -: 8];
            a2 = s[127-8*(4*c+2) -: 8];
            a3 = s[127-8*(4*c+3) -: 8];
            o[127-8*(4*c)   -: 8] = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
            o[127-8*(4*c+1) -: 8] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
            o[127-8*(4*c+2) -: 8] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
            o[127-8*(4*c+3) -: 8] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ rk[10];
        for (int r = 9; r >= 1; r--) s = inv_mix(inv_sub(inv_shr(s)) ^ rk[r]);
        return inv_sub(inv_shr(s)) ^ rk[0];
    endfunction

    function automatic logic [127:0] dp_fn(input logic [127:0] st, input logic [1:0] sel,
                                           input logic [KIW-1:0] idx);
        if (int'(idx) > NR) return '0;
        case (sel)
            2'd0:    return st ^ rk[idx];
            2'd1:    return inv_mix(inv_sub(inv_shr(st)) ^ rk[idx]);
            2'd2:    return inv_sub(inv_shr(st)) ^ rk[idx];
            default: return st;
        endcase
    endfunction

    always_comb dp_result = dp_fn(dp_state, dp_sel, dp_key_idx);

    // ---------------- behavioural model ----------------
    // m_k counts cycles since the key became usable: 0 = key-add step,
    // 1..NR-1 = full rounds, NR = final round, NR+1 = result held.
    bit           m_on = 0;
    bit           m_active = 0;
    bit           m_keyok = 0;
    bit           m_done_led = 0;
    bit           m_zero = 0;
    int           m_k = 0;
    logic [127:0] m_ct = '0;
    logic [127:0] m_plain = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_on <= 1; m_active <= 0; m_keyok <= 0; m_k <= 0;
            m_done_led <= 0; m_zero <= 1;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active <= 1; m_keyok <= key_valid; m_k <= 0; m_done_led <= 0;
                m_ct <= in_data; m_plain <= aes_dec(in_data); m_zero <= 0;
            end
        end else if (!m_keyok) begin
            if (key_valid) m_keyok <= 1;
        end else if (m_k <= NR) begin
            if (m_k == NR) m_done_led <= 1;
            m_k <= m_k + 1;
        end else if (out_ready) begin
            m_active <= 0;
        end
    end

    always @(negedge clk) begin
        bit          exp_done;
        logic [1:0]  e_sel;
        int          e_idx;
        if (m_on) begin
            exp_done = m_active && m_keyok && (m_k == NR + 1);
            e_sel = 2'd3;
            e_idx = 0;
            if (m_active && m_keyok && !exp_done) begin
                if (m_k == 0)       begin e_sel = 2'd0; e_idx = NR; end
                else if (m_k == NR) begin e_sel = 2'd2; e_idx = 0; end
                else                begin e_sel = 2'd1; e_idx = NR - m_k; end
            end
            chk("in_ready",   in_ready,   !m_active);
            chk("busy",       busy,       m_active);
            chk("out_valid",  out_valid,  exp_done);
            chk("done_led",   done_led,   m_done_led);
            chk("dp_sel",     dp_sel,     e_sel);
            chk("dp_key_idx", dp_key_idx, e_idx);
            if (exp_done) chk("out_data", out_data, m_plain);
            if (m_active && (!m_keyok || m_k == 0)) chk("dp_state_load", dp_state, m_ct);
            if (m_zero) chk("dp_state_zero", dp_state, 0);
        end
    end

    // ---------------- trace capture ----------------
    bit tracing = 0;
    int tr_idx[$];
    int tr_sel[$];
    always @(negedge clk) begin
        if (tracing && dp_sel != 2'd3) begin
            tr_idx.push_back(int'(dp_key_idx));
            tr_sel.push_back(int'(dp_sel));
        end
    end

    // ---------------- driver ----------------
    task automatic send_block(input logic [127:0] ct, input int kv_delay, input int hold,
                              output int lat, output int held);
        int c0, guard;
        logic [127:0] first;
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        in_data = ct; in_valid = 1'b1; key_valid = (kv_delay == 0);
        out_ready = (hold == 0);
        c0 = cyc;
        @(negedge clk);
        if (kv_delay > 0) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            repeat (kv_delay - 1) @(negedge clk);
            key_valid = 1'b1;
            @(negedge clk);
        end
        guard = 0;
        while (!out_valid && guard < 200) begin
            in_valid = 1'b1;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            key_valid = 1'($urandom % 2);
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        key_valid = 1'b1;
        if (guard >= 200) chk("out_valid_timeout", 0, 1);
        lat = cyc - (c0 + 1);
        held = 0;
        if (hold > 0) begin
            first = out_data;
            for (int i = 0; i < hold; i++) begin
                if (out_valid && !in_ready && out_data === first) held++;
                @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk("in_ready_after_release", in_ready, 1);
        end else begin
            @(negedge clk);
        end
    endtask

    int exp_idx[11] = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    int exp_sel[11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2};

    initial begin
        int lat, held, guard;
        logic [7:0] bi;
        logic [127:0] rnd;

        init_tables();
        chk("sbox_00", sbox[0], 8'h63);
        bi = 8'h53;
        chk("sbox_53", sbox[bi], 8'hed);
        chk("model_fips197", aes_dec(CT), PT);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dp_sel", dp_sel, 2'd3);
        chk("rst_dp_state", dp_state, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_led", done_led, 0);
        @(negedge clk);

        // Basic block with trace.
        tracing = 1;
        send_block(CT, 0, 0, lat, held);
        tracing = 0;
        chk("latency_basic", lat, 11);
        chk("done_led_set", done_led, 1);
        chk("trace_len", tr_idx.size(), 11);
        if (tr_idx.size() == 11)
            for (int i = 0; i < 11; i++) begin
                chk("trace_idx", tr_idx[i], exp_idx[i]);
                chk("trace_sel", tr_sel[i], exp_sel[i]);
            end

        // Key not ready at accept.
        send_block(CT, 3, 0, lat, held);
        chk("latency_wait3", lat, 14);

        // Consumer stalls for 5 cycles.
        send_block(CT, 0, 5, lat, held);
        chk("stall_held", held, 5);

        // Reset in the middle of a block.
        in_data = CT; in_valid = 1'b1; key_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (dp_key_idx != 4'd5 && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) chk("reset_wait_timeout", 0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_done_led", done_led, 0);
        chk("midrst_dp_state", dp_state, 0);
        @(negedge clk);
        send_block(CT, 0, 0, lat, held);
        chk("latency_after_reset", lat, 11);

        // A few random blocks with varying waits.
        for (int n = 0; n < 4; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            send_block(rnd, n % 3, n % 2, lat, held);
            chk("latency_random", lat, 11 + (n % 3));
        end

`ifdef AES_DEC_CTRL_BLKCNT_EN
        force dut.blk_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.blk_cnt_q;
        chk("blk_cnt_preset", blk_cnt, 16'hFFFF);
        send_block(CT, 0, 0, lat, held);
        chk("blk_cnt_wrap", blk_cnt, 16'h0000);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
